// File: rtl/renas_branch_predictor.sv
// Direction predictor with a single pattern history table of saturating counters,
// indexed by gshare (PC xor global history) or bimodal (PC only), self-initialising after reset.
module renas_branch_predictor #(
    parameter int HISTORY_LENGTH = 8,
    parameter int COUNTER_WIDTH  = 2,
    parameter int MODE           = 0,
    parameter int PC_LENGTH      = 32,
    parameter int BYTE_OFFSET    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pred_req_i,
    input  logic [PC_LENGTH-1:0]      pred_pc_i,
    output logic                      pred_valid_o,
    output logic                      pred_take_o,
    output logic [HISTORY_LENGTH-1:0] pred_ghr_o,
    output logic [COUNTER_WIDTH-1:0]  pred_counter_o,
    input  logic                      upd_valid_i,
    input  logic [PC_LENGTH-1:0]      upd_pc_i,
    input  logic [HISTORY_LENGTH-1:0] upd_ghr_i,
    input  logic                      upd_actual_i,
    input  logic                      upd_wrong_i,
    output logic                      busy_o
);

    localparam int H     = HISTORY_LENGTH;
    localparam int W     = COUNTER_WIDTH;
    localparam int DEPTH = 1 << H;

    localparam logic [W-1:0] CNT_INIT = W'((1 << (W - 1)) - 1);
    localparam logic [W-1:0] CNT_MAX  = '1;
    localparam logic [H-1:0] IDX_LAST = H'(DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t         r_state;
    logic [H-1:0]   r_init_idx;
    logic [H-1:0]   r_ghr;
    logic [W-1:0]   r_pht [DEPTH];

    logic           r_pred_valid;
    logic [W-1:0]   r_pred_counter;
    logic [H-1:0]   r_pred_ghr;

    logic [H-1:0]   w_pred_hist;
    logic [H-1:0]   w_upd_hist;
    logic [H-1:0]   w_pred_idx;
    logic [H-1:0]   w_upd_idx;
    logic [W-1:0]   w_upd_cnt_rd;
    logic [W-1:0]   w_upd_cnt_next;
    logic           w_spec_taken;
    logic           w_recover;
    logic           w_unused_bits;

    // Bimodal mode simply drops the history term from the index hash.
    generate
        if (MODE == 0) begin : g_gshare
            assign w_pred_hist = r_ghr;
            assign w_upd_hist  = upd_ghr_i;
        end else begin : g_bimodal
            assign w_pred_hist = '0;
            assign w_upd_hist  = '0;
        end
    endgenerate

    assign w_pred_idx    = pred_pc_i[BYTE_OFFSET +: H] ^ w_pred_hist;
    assign w_upd_idx     = upd_pc_i[BYTE_OFFSET +: H] ^ w_upd_hist;
    assign w_spec_taken  = r_pht[w_pred_idx][W-1];
    assign w_upd_cnt_rd  = r_pht[w_upd_idx];
    assign w_recover     = upd_valid_i & upd_wrong_i;
    assign w_unused_bits = ^{pred_pc_i, upd_pc_i, upd_ghr_i};

    always_comb begin
        w_upd_cnt_next = w_upd_cnt_rd;
        if (upd_actual_i) begin
            if (w_upd_cnt_rd != CNT_MAX) begin
                w_upd_cnt_next = w_upd_cnt_rd + 1'b1;
            end
        end else begin
            if (w_upd_cnt_rd != '0) begin
                w_upd_cnt_next = w_upd_cnt_rd - 1'b1;
            end
        end
    end

    // Table storage kept free of reset so it maps onto RAM; INIT rewrites every entry.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (r_state == ST_INIT) begin
                r_pht[r_init_idx] <= CNT_INIT;
            end else if (upd_valid_i) begin
                r_pht[w_upd_idx] <= w_upd_cnt_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_INIT;
            r_init_idx     <= '0;
            r_ghr          <= '0;
            r_pred_valid   <= 1'b0;
            r_pred_counter <= '0;
            r_pred_ghr     <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_pred_valid <= 1'b0;
                    r_init_idx   <= r_init_idx + 1'b1;
                    if (r_init_idx == IDX_LAST) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_pred_valid <= pred_req_i;
                    if (pred_req_i) begin
                        r_pred_counter <= r_pht[w_pred_idx];
                        r_pred_ghr     <= r_ghr;
                    end
                    // A mispredict recovery wins over the speculative shift of the same cycle.
                    if (w_recover) begin
                        r_ghr <= {upd_ghr_i[H-2:0], upd_actual_i};
                    end else if (pred_req_i) begin
                        r_ghr <= {r_ghr[H-2:0], w_spec_taken};
                    end
                end
            endcase
        end
    end

    assign pred_valid_o   = r_pred_valid;
    assign pred_take_o    = r_pred_counter[W-1];
    assign pred_ghr_o     = r_pred_ghr;
    assign pred_counter_o = r_pred_counter;
    assign busy_o         = (r_state == ST_INIT);

endmodule

// File: tb/tb_renas_branch_predictor.sv
// Bench for renas_branch_predictor (H=4, W=2, gshare): directed table, corner sequences,
// and randomized traffic against an integer-array reference model.
module tb_renas_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pred_req_i;
    logic [31:0] pred_pc_i;
    logic        pred_valid_o;
    logic        pred_take_o;
    logic [3:0]  pred_ghr_o;
    logic [1:0]  pred_counter_o;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic [3:0]  upd_ghr_i;
    logic        upd_actual_i;
    logic        upd_wrong_i;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    renas_branch_predictor #(
        .HISTORY_LENGTH(4),
        .COUNTER_WIDTH (2),
        .MODE          (0),
        .PC_LENGTH     (32),
        .BYTE_OFFSET   (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pred_req_i    (pred_req_i),
        .pred_pc_i     (pred_pc_i),
        .pred_valid_o  (pred_valid_o),
        .pred_take_o   (pred_take_o),
        .pred_ghr_o    (pred_ghr_o),
        .pred_counter_o(pred_counter_o),
        .upd_valid_i   (upd_valid_i),
        .upd_pc_i      (upd_pc_i),
        .upd_ghr_i     (upd_ghr_i),
        .upd_actual_i  (upd_actual_i),
        .upd_wrong_i   (upd_wrong_i),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] pc;
        logic        uv;
        logic [31:0] upc;
        logic [3:0]  ughr;
        logic        act;
        logic        wrong;
        logic        ev;
        logic        et;
        logic [3:0]  eg;
        logic [1:0]  ec;
    } vec_t;

    vec_t tbl [18];

    // Reference model: plain integers, 16 counters in 0..3, 4-bit history.
    int m_pht [16];
    int m_ghr;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic [31:0] pc, input logic uv,
                         input logic [31:0] upc, input logic [3:0] ughr,
                         input logic act, input logic wrong);
        pred_req_i   = req;
        pred_pc_i    = pc;
        upd_valid_i  = uv;
        upd_pc_i     = upc;
        upd_ghr_i    = ughr;
        upd_actual_i = act;
        upd_wrong_i  = wrong;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    endtask

    // Releases reset and counts busy cycles while throwing random traffic that must be ignored.
    task automatic release_and_wait_init(input string name);
        int cnt;
        cnt   = 0;
        rst_n = 1'b1;
        while (busy_o === 1'b1 && cnt < 100) begin
            drive(1'($urandom), $urandom, 1'($urandom), $urandom, 4'($urandom),
                  1'($urandom), 1'($urandom));
            step();
            cnt++;
            check({name, "_init_valid"}, int'(pred_valid_o), 0);
        end
        idle();
        check({name, "_busy_cycles"}, cnt, 16);
        $display("%s: init finished after %0d cycles", name, cnt);
    endtask

    function automatic int idx_of(input logic [31:0] pc, input int g);
        return int'((pc >> 2) & 32'd15) ^ g;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_pht[i] = 1;
        m_ghr = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (3) step();
        check("rst_busy",    int'(busy_o),         1);
        check("rst_valid",   int'(pred_valid_o),   0);
        check("rst_take",    int'(pred_take_o),    0);
        check("rst_ghr",     int'(pred_ghr_o),     0);
        check("rst_counter", int'(pred_counter_o), 0);
        release_and_wait_init("init0");

        //           req  pc       uv   upc      ughr act wrong ev et eg  ec
        tbl[0]  = '{1'b1, 32'h100, 1'b0, 32'h0,   4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 2'd1};
        tbl[1]  = '{1'b0, 32'h0,   1'b1, 32'h100, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0};
        tbl[2]  = '{1'b0, 32'h0,   1'b1, 32'h100, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0};
        tbl[3]  = '{1'b1, 32'h100, 1'b0, 32'h0,   4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 2'd3};
        tbl[4]  = '{1'b0, 32'h0,   1'b1, 32'h100, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0};
        tbl[5]  = '{1'b0, 32'h0,   1'b1, 32'h100, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0};
        tbl[6]  = '{1'b0, 32'h0,   1'b1, 32'h100, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0};
        tbl[7]  = '{1'b0, 32'h0,   1'b1, 32'h100, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0};
        tbl[8]  = '{1'b1, 32'h104, 1'b0, 32'h0,   4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h1, 2'd2};
        tbl[9]  = '{1'b0, 32'h0,   1'b1, 32'h01C, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 2'd0};
        tbl[10] = '{1'b1, 32'h100, 1'b0, 32'h0,   4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 2'd2};
        tbl[11] = '{1'b1, 32'h108, 1'b0, 32'h0,   4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h1, 2'd1};
        tbl[12] = '{1'b1, 32'h100, 1'b0, 32'h0,   4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 2'd1};
        tbl[13] = '{1'b1, 32'h100, 1'b1, 32'h100, 4'h5, 1'b0, 1'b1, 1'b1, 1'b0, 4'h4, 2'd1};
        tbl[14] = '{1'b1, 32'h100, 1'b0, 32'h0,   4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hA, 2'd1};
        tbl[15] = '{1'b1, 32'h100, 1'b1, 32'h110, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h4, 2'd1};
        tbl[16] = '{1'b0, 32'h0,   1'b1, 32'h01C, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 2'd0};
        tbl[17] = '{1'b1, 32'h100, 1'b0, 32'h0,   4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h4, 2'd2};

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].req, tbl[i].pc, tbl[i].uv, tbl[i].upc, tbl[i].ughr,
                  tbl[i].act, tbl[i].wrong);
            step();
            check($sformatf("vec%0d_valid", i), int'(pred_valid_o), int'(tbl[i].ev));
            if (tbl[i].ev) begin
                check($sformatf("vec%0d_take", i),    int'(pred_take_o),    int'(tbl[i].et));
                check($sformatf("vec%0d_ghr", i),     int'(pred_ghr_o),     int'(tbl[i].eg));
                check($sformatf("vec%0d_counter", i), int'(pred_counter_o), int'(tbl[i].ec));
            end
            $display("vec%0d: valid=%0d take=%0d ghr=%h counter=%0d", i,
                     pred_valid_o, pred_take_o, pred_ghr_o, pred_counter_o);
        end

        // Reset pulse in RUN with a lookup pending: reset must win and clear outputs.
        drive(1'b1, 32'h100, 1'b1, 32'h100, 4'h0, 1'b1, 1'b0);
        rst_n = 1'b0;
        step();
        check("rst2_busy",    int'(busy_o),         1);
        check("rst2_valid",   int'(pred_valid_o),   0);
        check("rst2_counter", int'(pred_counter_o), 0);
        check("rst2_ghr",     int'(pred_ghr_o),     0);
        release_and_wait_init("init1");
        drive(1'b1, 32'h100, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        step();
        idle();
        check("post_rst_valid",   int'(pred_valid_o),   1);
        check("post_rst_counter", int'(pred_counter_o), 1);
        check("post_rst_take",    int'(pred_take_o),    0);
        $display("post-reset lookup: counter=%0d take=%0d", pred_counter_o, pred_take_o);

        // Randomized traffic; the lookup above predicted not-taken so history is still zero.
        model_reset();
        for (int t = 0; t < 400; t++) begin
            logic        req, uv, act, wrong;
            logic [31:0] pc, upc;
            logic [3:0]  ughr;
            int li, ui, exp_cnt, exp_take, exp_ghr;
            req   = 1'($urandom_range(0, 3) != 0);
            pc    = $urandom;
            uv    = 1'($urandom);
            upc   = (t % 3 == 0) ? pc : $urandom;
            ughr  = (t % 3 == 0) ? 4'(m_ghr) : 4'($urandom);
            act   = 1'($urandom);
            wrong = 1'($urandom_range(0, 3) == 0);
            li       = idx_of(pc, m_ghr);
            exp_cnt  = m_pht[li];
            exp_take = (exp_cnt >= 2) ? 1 : 0;
            exp_ghr  = m_ghr;
            if (uv) begin
                ui = idx_of(upc, int'(ughr));
                if (act) m_pht[ui] = (m_pht[ui] < 3) ? m_pht[ui] + 1 : 3;
                else     m_pht[ui] = (m_pht[ui] > 0) ? m_pht[ui] - 1 : 0;
            end
            if (uv && wrong) m_ghr = ((int'(ughr) << 1) | int'(act)) & 15;
            else if (req)    m_ghr = ((m_ghr << 1) | exp_take) & 15;
            drive(req, pc, uv, upc, ughr, act, wrong);
            step();
            check("rnd_busy",  int'(busy_o),       0);
            check("rnd_valid", int'(pred_valid_o), int'(req));
            if (req) begin
                check("rnd_take",    int'(pred_take_o),    exp_take);
                check("rnd_ghr",     int'(pred_ghr_o),     exp_ghr);
                check("rnd_counter", int'(pred_counter_o), exp_cnt);
                $display("rnd%0d: pc=%h idx=%0d counter=%0d take=%0d ghr=%h", t, pc, li,
                         pred_counter_o, pred_take_o, pred_ghr_o);
            end else begin
                $display("rnd%0d: no lookup, valid=%0d", t, pred_valid_o);
            end
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/renas_branch_predictor.md
RENAS_BRANCH_PREDICTOR -- requirements
Module: renas_branch_predictor

Interface
REQ-001 SHALL have parameter HISTORY_LENGTH, default 8: GHR width; PHT has 2**HISTORY_LENGTH entries.
REQ-002 SHALL have parameter COUNTER_WIDTH, default 2: width of each saturating counter, legal range 2..4.
REQ-003 SHALL have parameter MODE, default 0: 0 = gshare index, 1 = bimodal index.
REQ-004 SHALL have parameter PC_LENGTH, default 32: PC width.
REQ-005 SHALL have parameter BYTE_OFFSET, default 2: low PC bits dropped before indexing.
REQ-006 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-007 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-008 SHALL have port pred_req_i  in  1  fetch-stage lookup request.
REQ-009 SHALL have port pred_pc_i  in  PC_LENGTH  PC being looked up.
REQ-010 SHALL have port pred_valid_o  out  1  prediction outputs valid this cycle.
REQ-011 SHALL have port pred_take_o  out  1  predicted direction, 1 = taken.
REQ-012 SHALL have port pred_ghr_o  out  HISTORY_LENGTH  GHR snapshot used for the lookup; returned later on upd_ghr_i.
REQ-013 SHALL have port pred_counter_o  out  COUNTER_WIDTH  counter value read.
REQ-014 SHALL have port upd_valid_i  in  1  resolved-branch update from EX.
REQ-015 SHALL have port upd_pc_i  in  PC_LENGTH  PC of the resolved branch.
REQ-016 SHALL have port upd_ghr_i  in  HISTORY_LENGTH  GHR snapshot captured at prediction.
REQ-017 SHALL have port upd_actual_i  in  1  resolved direction.
REQ-018 SHALL have port upd_wrong_i  in  1  resolved branch was mispredicted.
REQ-019 SHALL have port busy_o  out  1  PHT initialisation in progress.

Function
REQ-020 Index SHALL be pc[BYTE_OFFSET+H-1:BYTE_OFFSET] XOR GHR when MODE=0, and the same PC field alone when MODE=1 (H = HISTORY_LENGTH).
REQ-021 Prediction SHALL be registered: pred_req_i in cycle N -> pred_valid_o=1 with take/ghr/counter in cycle N+1 only; pred_valid_o=0 otherwise.
REQ-022 pred_take_o SHALL equal the MSB of the counter read.
REQ-023 On an accepted pred_req_i without a recovering update, the GHR SHALL shift left with the predicted bit inserted at LSB.
REQ-024 On upd_valid_i & upd_wrong_i, the GHR SHALL load {upd_ghr_i[H-2:0], upd_actual_i}; this overrides any speculative shift in the same cycle.
REQ-025 On upd_valid_i, the counter at index(upd_pc_i, upd_ghr_i) SHALL increment when upd_actual_i=1 and decrement when it is 0, saturating at 2**W-1 and 0 (W = COUNTER_WIDTH).
REQ-026 A lookup and an update to the same index in the same cycle SHALL return the pre-update counter value (no bypass); the update is not lost.
REQ-027 The FSM SHALL have two states. INIT: writes one PHT entry per cycle, index 0..2**H-1, value 2**(W-1)-1 (weakly not-taken). RUN: normal operation.
REQ-028 INIT -> RUN SHALL occur after the last index is written; busy_o=1 exactly in INIT.
REQ-029 In INIT, pred_req_i and upd_valid_i SHALL be ignored: no GHR change, no PHT write, pred_valid_o stays 0.

Reset
REQ-030 While rst_n=0 at a clock edge: FSM SHALL enter INIT with init index 0; GHR=0; pred_valid_o=0, pred_take_o=0, pred_ghr_o=0, pred_counter_o=0; busy_o=1.
REQ-031 Reset asserted mid-INIT or mid-RUN SHALL restart full initialisation; no prior PHT content survives.

Verification (H=4, W=2, MODE=0)
REQ-032 Release rst_n -> busy_o=1 for exactly 16 cycles then 0; lookup pc 0x100 -> next cycle pred_valid_o=1, take=0, counter=01, ghr=0000.
REQ-033 Two updates pc 0x100, ghr 0000, actual=1, wrong=0 -> lookup pc 0x100 with GHR=0000 returns counter=11, take=1.
REQ-034 Three more taken updates -> counter stays 11; one not-taken update -> 10, take still 1.
REQ-035 GHR=0000, lookups predicting 1 then 0 -> pred_ghr_o shows 0000 then 0001; internal GHR becomes 0010.
REQ-036 Same cycle: pred_req_i=1 plus upd wrong=1, upd_ghr_i=0101, actual=0 -> GHR=1010, no speculative shift; next lookup shows pred_ghr_o=1010.
REQ-037 rst_n pulsed low for 1 cycle in RUN after training -> busy_o=1 for 16 cycles, then lookup pc 0x100 returns counter=01.
